// File: rtl/fifo_wr_arb_rr.sv
// fifo_wr_arb_rr: round-robin arbiter sharing one async-FIFO write port among
// NUM_REQ packet sources. A grant is held for a whole packet or at most
// MAX_BURST beats, so packets from different sources never interleave.
// Everything runs in the clk_w domain.
//
// Optional feature macro: FIFO_WR_ARB_HIPRI_EN adds the hipri input. When any
// valid source is flagged high priority, arbitration only considers the
// flagged sources.
//
// Ports:
//   clk_w, rst_n  write-side clock, synchronous active-low reset
//   src_valid     per-source beat valid
//   src_data      per-source beat data, source i at [i*DW +: DW]
//   src_last      per-source last beat of packet
//   src_ready     per-source beat accepted this cycle (combinational)
//   hipri         per-source high-priority flag (FIFO_WR_ARB_HIPRI_EN only)
//   fifo_full     FIFO full flag
//   fifo_w_req    FIFO write strobe (combinational)
//   fifo_data     FIFO write data (combinational mux of the owner)
//   grant_id      current owner, valid while busy=1
//   busy          a grant is active
module fifo_wr_arb_rr #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DW        = 64,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                       clk_w,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         src_valid,
  input  logic [NUM_REQ*DW-1:0]      src_data,
  input  logic [NUM_REQ-1:0]         src_last,
  output logic [NUM_REQ-1:0]         src_ready,
`ifdef FIFO_WR_ARB_HIPRI_EN
  input  logic [NUM_REQ-1:0]         hipri,
`endif
  input  logic                       fifo_full,
  output logic                       fifo_w_req,
  output logic [DW-1:0]              fifo_data,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int unsigned IDW = $clog2(NUM_REQ);
  localparam int unsigned CW  = $clog2(MAX_BURST) + 1;
  localparam int unsigned SW  = IDW + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

  typedef enum logic {IDLE, BURST} state_e;

  state_e               state_q, state_d;
  logic [IDW-1:0]       grant_id_q, grant_id_d;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]        beat_cnt_q, beat_cnt_d;

  logic [NUM_REQ-1:0]   req_vec;
  logic [2*NUM_REQ-1:0] req_rot;
  logic [IDW-1:0]       pick;
  logic                 pick_vld;
  logic [SW-1:0]        pick_sum;
  logic                 cur_valid;
  logic                 cur_last;
  logic                 xfer;

  // Eligible requester set
  always_comb begin
`ifdef FIFO_WR_ARB_HIPRI_EN
    req_vec = (|(src_valid & hipri)) ? (src_valid & hipri) : src_valid;
`else
    req_vec = src_valid;
`endif
  end

  // First eligible index at or after rr_ptr, wrapping; the doubled vector
  // rotated by rr_ptr puts the scan start at bit 0.
  always_comb begin
    req_rot  = {req_vec, req_vec} >> rr_ptr_q;
    pick     = rr_ptr_q;
    pick_vld = 1'b0;
    pick_sum = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!pick_vld && req_rot[i]) begin
        pick_sum = SW'(rr_ptr_q) + SW'(i);
        if (pick_sum >= SW'(NUM_REQ)) begin
          pick_sum = pick_sum - SW'(NUM_REQ);
        end
        pick     = IDW'(pick_sum);
        pick_vld = 1'b1;
      end
    end
  end

  // Owner's valid/last/data, zero-latency to the FIFO
  always_comb begin
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    fifo_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == IDW'(i)) begin
        cur_valid = src_valid[i];
        cur_last  = src_last[i];
        fifo_data = src_data[i*DW +: DW];
      end
    end
  end

  // Next-state and transfer logic
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    xfer       = 1'b0;
    src_ready  = '0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_id_d = pick;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        xfer = cur_valid & ~fifo_full;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          src_ready[i] = xfer & (grant_id_q == IDW'(i));
        end
        if (xfer) begin
          beat_cnt_d = beat_cnt_q + CW'(1);
          // last beat and burst limit may coincide: one exit, one advance
          if (cur_last || (beat_cnt_q == LAST_CNT)) begin
            state_d  = IDLE;
            rr_ptr_d = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + IDW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk_w) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign fifo_w_req = xfer;
  assign busy       = (state_q == BURST);
  assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_fifo_wr_arb_rr.sv
// Directed bench for fifo_wr_arb_rr with default parameters (4 sources,
// 64-bit beats, 16-beat bursts). Sources are modelled as packet generators
// whose beat i of source s carries data {s, i}.
module tb_fifo_wr_arb_rr;

  localparam int unsigned NUM_REQ   = 4;
  localparam int unsigned DW        = 64;
  localparam int unsigned MAX_BURST = 16;

  logic                  clk_w = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    src_valid;
  logic [NUM_REQ*DW-1:0] src_data;
  logic [NUM_REQ-1:0]    src_last;
  logic [NUM_REQ-1:0]    src_ready;
  logic                  fifo_full;
  logic                  fifo_w_req;
  logic [DW-1:0]         fifo_data;
  logic [1:0]            grant_id;
  logic                  busy;
`ifdef FIFO_WR_ARB_HIPRI_EN
  logic [NUM_REQ-1:0]    hipri;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  int remaining [NUM_REQ];
  int pos       [NUM_REQ];
  int plen      [NUM_REQ];
  bit refill    [NUM_REQ];

  fifo_wr_arb_rr #(
    .NUM_REQ  (NUM_REQ),
    .DW       (DW),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk_w     (clk_w),
    .rst_n     (rst_n),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_last  (src_last),
    .src_ready (src_ready),
`ifdef FIFO_WR_ARB_HIPRI_EN
    .hipri     (hipri),
`endif
    .fifo_full (fifo_full),
    .fifo_w_req(fifo_w_req),
    .fifo_data (fifo_data),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk_w = ~clk_w;

  function automatic logic [63:0] mk(input int s, input int k);
    return (64'(s) << 56) | 64'(k);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive source pins from the packet-generator state
  task automatic apply();
    for (int i = 0; i < NUM_REQ; i++) begin
      src_valid[i]           = (remaining[i] > 0);
      src_last[i]            = (remaining[i] == 1);
      src_data[i*DW +: DW]   = mk(i, pos[i]);
    end
  endtask

  task automatic cfg(input int s, input int len, input bit rf);
    plen[s]      = len;
    remaining[s] = len;
    pos[s]       = 0;
    refill[s]    = rf;
  endtask

  // One clock: sources advance on the beats accepted this cycle
  task automatic cyc();
    logic [NUM_REQ-1:0] rdy;
    #1;
    rdy = src_ready;
    @(posedge clk_w);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rdy[i]) begin
        pos[i]++;
        remaining[i]--;
        if (remaining[i] == 0 && refill[i]) remaining[i] = plen[i];
      end
    end
    apply();
  endtask

  task automatic ck(input string tag, input logic b, input logic [1:0] g,
                    input logic w, input logic [3:0] r, input logic [63:0] d);
    #1;
    chk({tag, "/busy"}, 64'(busy), 64'(b));
    chk({tag, "/wreq"}, 64'(fifo_w_req), 64'(w));
    chk({tag, "/ready"}, 64'(src_ready), 64'(r));
    if (b) begin
      chk({tag, "/gid"}, 64'(grant_id), 64'(g));
      chk({tag, "/data"}, fifo_data, d);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    fifo_full = 1'b0;
    src_data  = '0;
`ifdef FIFO_WR_ARB_HIPRI_EN
    hipri     = '0;
`endif
    for (int i = 0; i < NUM_REQ; i++) cfg(i, 0, 1'b0);
    apply();
    cyc();
    cyc();

    // Reset state
    ck("rst", 1'b0, 2'd0, 1'b0, 4'b0000, 64'd0);
    chk("rst/gid", 64'(grant_id), 64'd0);

    // Two 3-beat packets on sources 0 and 2
    rst_n = 1'b1;
    cfg(0, 3, 1'b0);
    cfg(2, 3, 1'b0);
    apply();
    ck("t1.idle", 1'b0, 2'd0, 1'b0, 4'b0000, 64'd0);
    cyc();
    for (int k = 0; k < 3; k++) begin
      ck("t1.s0", 1'b1, 2'd0, 1'b1, 4'b0001, mk(0, k));
      cyc();
    end
    ck("t1.gap", 1'b0, 2'd0, 1'b0, 4'b0000, 64'd0);
    cyc();
    for (int k = 0; k < 3; k++) begin
      ck("t1.s2", 1'b1, 2'd2, 1'b1, 4'b0100, mk(2, k));
      cyc();
    end

    // FIFO full for 5 cycles mid-packet (rr_ptr=3, only source 1 valid)
    cfg(1, 4, 1'b0);
    apply();
    ck("t3.idle", 1'b0, 2'd0, 1'b0, 4'b0000, 64'd0);
    cyc();
    for (int k = 0; k < 2; k++) begin
      ck("t3.pre", 1'b1, 2'd1, 1'b1, 4'b0010, mk(1, k));
      cyc();
    end
    fifo_full = 1'b1;
    for (int n = 0; n < 5; n++) begin
      ck("t3.full", 1'b1, 2'd1, 1'b0, 4'b0000, mk(1, 2));
      cyc();
    end
    fifo_full = 1'b0;
    for (int k = 2; k < 4; k++) begin
      ck("t3.post", 1'b1, 2'd1, 1'b1, 4'b0010, mk(1, k));
      cyc();
    end

    // 40-beat packet on source 1 split at 16 beats, source 3 slotted in (rr_ptr=2)
    cfg(1, 40, 1'b0);
    apply();
    ck("t2.idle", 1'b0, 2'd0, 1'b0, 4'b0000, 64'd0);
    cyc();
    cfg(3, 2, 1'b0);
    apply();
    for (int k = 0; k < 16; k++) begin
      ck("t2.b1", 1'b1, 2'd1, 1'b1, 4'b0010, mk(1, k));
      cyc();
    end
    ck("t2.gap1", 1'b0, 2'd0, 1'b0, 4'b0000, 64'd0);
    cyc();
    for (int k = 0; k < 2; k++) begin
      ck("t2.s3", 1'b1, 2'd3, 1'b1, 4'b1000, mk(3, k));
      cyc();
    end
    ck("t2.gap2", 1'b0, 2'd0, 1'b0, 4'b0000, 64'd0);
    cyc();
    for (int k = 16; k < 32; k++) begin
      ck("t2.b2", 1'b1, 2'd1, 1'b1, 4'b0010, mk(1, k));
      cyc();
    end
    ck("t2.gap3", 1'b0, 2'd0, 1'b0, 4'b0000, 64'd0);
    cyc();
    for (int k = 32; k < 40; k++) begin
      ck("t2.b3", 1'b1, 2'd1, 1'b1, 4'b0010, mk(1, k));
      cyc();
    end

    // Reset during a burst (rr_ptr=2 would pick source 2 without reset)
    cfg(0, 10, 1'b0);
    cfg(2, 10, 1'b0);
    apply();
    ck("t5.idle", 1'b0, 2'd0, 1'b0, 4'b0000, 64'd0);
    cyc();
    for (int k = 0; k < 4; k++) begin
      ck("t5.s2", 1'b1, 2'd2, 1'b1, 4'b0100, mk(2, k));
      cyc();
    end
    rst_n = 1'b0;
    ck("t5.s2rst", 1'b1, 2'd2, 1'b1, 4'b0100, mk(2, 4));
    cyc();
    for (int i = 0; i < NUM_REQ; i++) cfg(i, 1, 1'b1);
    rst_n = 1'b1;
    apply();
    ck("t5.after", 1'b0, 2'd0, 1'b0, 4'b0000, 64'd0);
    chk("t5.after/gid", 64'(grant_id), 64'd0);
    cyc();

    // All four sources continuously valid with 1-beat packets
    for (int n = 0; n < 8; n++) begin
      ck("t4.rr", 1'b1, 2'(n % 4), 1'b1, 4'b0001 << (n % 4), mk(n % 4, n / 4));
      if (n == 7) begin
        for (int i = 0; i < NUM_REQ; i++) refill[i] = 1'b0;
      end
      cyc();
      if (n < 7) begin
        ck("t4.gap", 1'b0, 2'd0, 1'b0, 4'b0000, 64'd0);
        cyc();
      end
    end

    // 16-beat packet: last and burst limit coincide (rr_ptr=0)
    cfg(0, 16, 1'b0);
    cfg(1, 1, 1'b0);
    cfg(2, 1, 1'b0);
    cfg(3, 0, 1'b0);
    apply();
    ck("t6.idle", 1'b0, 2'd0, 1'b0, 4'b0000, 64'd0);
    cyc();
    for (int k = 0; k < 16; k++) begin
      ck("t6.s0", 1'b1, 2'd0, 1'b1, 4'b0001, mk(0, k));
      cyc();
    end
    ck("t6.gap1", 1'b0, 2'd0, 1'b0, 4'b0000, 64'd0);
    cyc();
    ck("t6.s1", 1'b1, 2'd1, 1'b1, 4'b0010, mk(1, 0));
    cyc();
    ck("t6.gap2", 1'b0, 2'd0, 1'b0, 4'b0000, 64'd0);
    cyc();
    ck("t6.s2", 1'b1, 2'd2, 1'b1, 4'b0100, mk(2, 0));
    cyc();
    ck("t6.end", 1'b0, 2'd0, 1'b0, 4'b0000, 64'd0);

`ifdef FIFO_WR_ARB_HIPRI_EN
    // High priority on source 3 (rr_ptr=3), then rotation resumes from rr_ptr=0
    for (int i = 0; i < NUM_REQ; i++) cfg(i, 1, 1'b1);
    hipri = 4'b1000;
    apply();
    ck("hp.idle", 1'b0, 2'd0, 1'b0, 4'b0000, 64'd0);
    cyc();
    for (int k = 0; k < 3; k++) begin
      ck("hp.s3", 1'b1, 2'd3, 1'b1, 4'b1000, mk(3, k));
      if (k == 2) hipri = 4'b0000;
      cyc();
      ck("hp.gap", 1'b0, 2'd0, 1'b0, 4'b0000, 64'd0);
      cyc();
    end
    ck("hp.s0", 1'b1, 2'd0, 1'b1, 4'b0001, mk(0, 0));
    cyc();
    ck("hp.gap2", 1'b0, 2'd0, 1'b0, 4'b0000, 64'd0);
    cyc();
    ck("hp.s1", 1'b1, 2'd1, 1'b1, 4'b0010, mk(1, 0));
    cyc();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb_rr.md
Name: fifo_wr_arb_rr

Overview:
Round-robin write-port arbiter in front of the byte-addressed async FIFO write side. Shares one FIFO write port (w_req/data_i/full) among NUM_REQ packet sources. A grant is held for a whole packet, or up to MAX_BURST beats, so packets from different sources do not interleave. Runs entirely in the clk_w domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DW, 64, beat width; equals the FIFO write width
MAX_BURST, 16, maximum beats per grant before forced re-arbitration (>=1)

Ports:
clk_w  input  1  write-side clock
rst_n  input  1  synchronous active-low reset
src_valid  input  NUM_REQ  per-source beat valid
src_data  input  NUM_REQ*DW  per-source beat data; source i occupies bits [i*DW +: DW]
src_last  input  NUM_REQ  per-source last beat of packet
src_ready  output  NUM_REQ  per-source beat accepted this cycle
fifo_full  input  1  FIFO full flag
fifo_w_req  output  1  FIFO write strobe
fifo_data  output  DW  FIFO write data
grant_id  output  clog2(NUM_REQ)  index of the current owner; valid while busy=1
busy  output  1  a grant is active (state BURST)

Behaviour:
- Interface: reset rst_n, synchronous, active-low; clock clk_w.
- Reset values: state=IDLE, busy=0, grant_id=0, rr_ptr=0, beat_cnt=0, src_ready=0, fifo_w_req=0.
- FSM has two states, IDLE and BURST.
- IDLE:
  - If any src_valid is set, select the first set bit scanning from rr_ptr upward, wrapping modulo NUM_REQ.
  - Register the selection in grant_id, clear beat_cnt, and go to BURST.
  - No beat is transferred in IDLE, so arbitration latency is exactly 1 cycle.
- BURST:
  - Beat transfer: fifo_w_req = src_valid[grant_id] & ~fifo_full.
  - src_ready[grant_id] = fifo_w_req. All other src_ready bits are 0.
  - fifo_data = src_data of grant_id. The mux is combinational, with zero-cycle latency from source to FIFO.
  - Each transfer increments beat_cnt. beat_cnt width is clog2(MAX_BURST)+1 and it never wraps.
  - Exit to IDLE after a transfer where src_last=1, or where beat_cnt reaches MAX_BURST-1 (i.e. the MAX_BURST-th beat).
  - On exit, rr_ptr <= (grant_id+1) mod NUM_REQ.
- Held grant:
  - fifo_full=1 or a source bubble (valid low) holds the grant indefinitely with no transfer.
  - Valid low mid-packet does not release the grant.
- Forced release: a packet longer than MAX_BURST is split. The source loses the grant after MAX_BURST beats and resumes when re-granted; its src_last is still honoured later.
- Fairness: a continuously requesting source waits at most NUM_REQ-1 grants.
- Back-to-back: every grant is followed by one IDLE cycle, so peak throughput is MAX_BURST/(MAX_BURST+1) for long packets.
- Simultaneous events: when src_last and the MAX_BURST limit coincide, there is a single exit and a single pointer advance.
- fifo_full is sampled combinationally in the same cycle. No write is issued while it is high, so the FIFO never drops a beat.
- Reset mid-BURST: return to IDLE immediately. The partial packet is not tracked; sources must also be reset.
- Data on non-granted sources is ignored.

Optional Feature:
FIFO_WR_ARB_HIPRI_EN
- Defined:
  - Adds port hipri input NUM_REQ (per-source high-priority flag, sampled in IDLE).
  - If any (src_valid & hipri) bit is set, round-robin runs only over that subset, still starting from rr_ptr. Otherwise normal round-robin applies.
  - rr_ptr updates identically in both cases.
  - Low-priority sources may starve while high-priority sources keep requesting.
- Undefined: the port is absent and behaviour is pure round-robin.

Test Plan:
- Reset, then src_valid=4'b0101 with 3-beat packets on sources 0 and 2 -> grants 0 then 2, with IDLE 1 cycle between. fifo_w_req is high for 3+3 cycles and data matches source order.
- Source 1 sends a 40-beat packet, MAX_BURST=16, with source 3 also requesting -> source 1 gets 16 beats, then source 3's packet, then source 1 gets 16 more, then 8. src_last is accepted on beat 40.
- fifo_full asserted for 5 cycles mid-packet -> fifo_w_req=0 and src_ready=0 for those cycles, grant_id unchanged, no beat lost or duplicated.
- All 4 sources continuously valid with 1-beat packets -> grant order 0,1,2,3,0,... and each grant is separated by one IDLE cycle.
- rst_n pulled low while in BURST at beat 5 -> next cycle busy=0, src_ready=0, rr_ptr=0, then the next arbitration picks the lowest valid index.
- With FIFO_WR_ARB_HIPRI_EN, src_valid=4'b1111 and hipri=4'b1000 -> source 3 is granted each arbitration until hipri clears, then rotation resumes from rr_ptr.
